mem_port_arbiter: RTL

- Shares one external memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Owns the port request/grant/response sequencing and generates the stall signals that freeze the requesting stages.
- Uses fixed data-over-fetch priority, plus a streak limit that guarantees fetch forward progress.
- Sits between the pipeline stages and the unified memory bus.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the fetch stage
// and the memory stage. Data requests win over fetch, but a fetch that is
// kept waiting sees at most MAX_DM_STREAK data grants before it is served.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction outstanding, arbitrating the two requesters
// ST_REQ   | mem_req high with fields frozen, waiting for mem_gnt
// ST_RSP   | request accepted, waiting for mem_rvalid
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_rvalid,
    output logic                if_stall,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_rvalid,
    output logic                dm_stall,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Streak limit fits in 4 bits (legal range 1..15).
    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DM_STREAK);

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic [3:0]        streak_q,    streak_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              dm_rvalid_q, dm_rvalid_d;

    logic grant_dm;
    logic grant_if;

    // Next-state logic: arbitration in IDLE, handshake in REQ, completion in RSP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        grant_dm    = 1'b0;
        grant_if    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_dm = dm_req && (!if_req || (streak_q < STREAK_LIMIT));
                grant_if = !grant_dm && if_req;

                // A fetch that is not waiting has no streak to protect.
                if (!if_req) begin
                    streak_d = 4'd0;
                end

                if (grant_dm) begin
                    owner_d     = OWN_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    state_d     = ST_REQ;
                    if (if_req && (streak_q < STREAK_LIMIT)) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_if) begin
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    streak_d    = 4'd0;
                    state_d     = ST_REQ;
                end
            end

            ST_REQ: begin
                // Responses are only meaningful once the bus has accepted us.
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RSP;
                end
            end

            ST_RSP: begin
                if (mem_rvalid) begin
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_we_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_rvalid_q <= dm_rvalid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_rvalid = dm_rvalid_q;

    // Stalls release in the completion cycle so the stage can advance.
    assign if_stall = if_req & ~if_rvalid_q;
    assign dm_stall = dm_req & ~dm_rvalid_q;

endmodule
